// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: drains a show-ahead FIFO into fixed-length Avalon-ST
// frames (valid/ready, sop/eop) for the forward FFT, rotating through
// NUM_CH channels, one frame per channel in turn.
// Optional build macro: FRAME_ZERO_PAD_EN -- when defined, an empty FIFO in
// mid-frame produces zero-valued beats instead of stalling the frame.
module fft_frame_feeder #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 4096,
  parameter int CNT_W     = 13,
  parameter int START_LVL = FRAME_LEN,
  parameter int NUM_CH    = 1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_usedw,
  output logic              fifo_rdreq,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic [CH_W-1:0]   src_chan,
  output logic              frame_done,
  output logic              underrun
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_LVL);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              issued_all;
  logic              load_en;
  logic              load_fill;
  logic              beat_acc;
  logic [DATA_W-1:0] load_word;

  // Load-slot arbitration: the output register may take a new beat when it
  // is empty or its current beat is being accepted, and beats remain.
  always_comb begin
    beat_acc   = src_valid & src_ready;
    load_en    = (state == STREAM) & ~issued_all & (~src_valid | src_ready);
    fifo_rdreq = load_en & ~fifo_empty;
    load_word  = fifo_empty ? '0 : fifo_q;
`ifdef FRAME_ZERO_PAD_EN
    load_fill  = load_en;
`else
    load_fill  = fifo_rdreq;
`endif
  end

  // Frame FSM with registered Avalon-ST outputs, index and channel rotation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      issued_all <= 1'b0;
      src_data   <= '0;
      src_valid  <= 1'b0;
      src_sop    <= 1'b0;
      src_eop    <= 1'b0;
      src_chan   <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && (fifo_usedw >= START_CNT)) begin
            state      <= STREAM;
            idx        <= '0;
            issued_all <= 1'b0;
          end
        end
        STREAM: begin
          if (load_en && fifo_empty) underrun <= 1'b1;
          if (load_fill) begin
            src_data  <= load_word;
            src_valid <= 1'b1;
            src_sop   <= (idx == '0);
            src_eop   <= (idx == IDX_LAST);
            // idx parks on the last index; issued_all marks the frame as fully loaded
            if (idx == IDX_LAST) issued_all <= 1'b1;
            else                 idx        <= idx + 1'b1;
          end else if (beat_acc) begin
            src_valid <= 1'b0;
            if (src_eop) begin
              frame_done <= 1'b1;
              state      <= IDLE;
              src_chan   <= (src_chan == CH_LAST) ? '0 : src_chan + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench for fft_frame_feeder (FRAME_LEN=8, START_LVL=4, NUM_CH=3).
module tb_fft_frame_feeder;

  localparam int DW = 16;
  localparam int FL = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [DW-1:0] fifo_q;
  logic          fifo_empty;
  logic [12:0]   fifo_usedw;
  logic          fifo_rdreq;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready;
  logic          src_sop;
  logic          src_eop;
  logic [CW-1:0] src_chan;
  logic          frame_done;
  logic          underrun;

  fft_frame_feeder #(
    .DATA_W(16), .FRAME_LEN(8), .CNT_W(13), .START_LVL(4), .NUM_CH(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw),
    .fifo_rdreq(fifo_rdreq), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop),
    .src_chan(src_chan), .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic [CW-1:0] ch;
  } beat_t;

  beat_t       exp_q[$];
  logic [DW-1:0] mfifo[$];

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int ur_cnt   = 0;
  int fd_cnt   = 0;
  int acc_cnt  = 0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [3:0]    prev_flags;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty = (mfifo.size() == 0);
    fifo_q     = fifo_empty ? '0 : mfifo[0];
    fifo_usedw = 13'(mfifo.size());
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) mfifo.push_back(DW'(first + i));
    refresh_fifo();
  endtask

  // One clock: sample rdreq where it is stable, pop the model FIFO after the edge.
  task automatic tick();
    logic pop_now;
    @(negedge clk);
    pop_now = fifo_rdreq;
    @(posedge clk);
    #1;
    if (pop_now && mfifo.size() > 0) void'(mfifo.pop_front());
    refresh_fifo();
  endtask

  task automatic expect_frame(input int first, input int nreal, input int ch);
    beat_t b;
    for (int i = 0; i < FL; i++) begin
      b.d   = (i < nreal) ? DW'(first + i) : '0;
      b.sop = (i == 0);
      b.eop = (i == FL - 1);
      b.ch  = CW'(ch);
      exp_q.push_back(b);
    end
  endtask

  // mode 0: src_ready held high; mode 1: ready pattern 1,0,0,1
  task automatic run_until_done(input int mode, input int bound, output int cycles);
    logic [3:0] pat;
    pat = 4'b1001;
    cycles = 0;
    for (int i = 0; i < bound; i++) begin
      src_ready = (mode == 0) ? 1'b1 : pat[3 - (i % 4)];
      tick();
      cycles++;
      if (frame_done) break;
    end
    src_ready = 1'b1;
    chk("frame_done_within_bound", 32'(frame_done), 32'd1);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_valid"}, 32'(src_valid), 0);
    chk({nm, "_data"},  32'(src_data), 0);
    chk({nm, "_flags"}, {28'd0, src_sop, src_eop, src_chan}, 0);
    chk({nm, "_pulses"}, {30'd0, frame_done, underrun}, 0);
    chk({nm, "_rdreq"}, 32'(fifo_rdreq), 0);
  endtask

  // Monitor: pops the scoreboard on every accepted beat and checks protocol rules.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (fifo_rdreq) begin
        rd_cnt++;
        chk("rdreq_while_empty", 32'(fifo_empty), 0);
      end
      if (underrun)   ur_cnt++;
      if (frame_done) fd_cnt++;
      if (prev_stall) begin
        chk("stall_valid_held", 32'(src_valid), 1);
        chk("stall_data_held", 32'(src_data), 32'(prev_data));
        chk("stall_flags_held", {28'd0, src_sop, src_eop, src_chan}, 32'(prev_flags));
      end
      if (src_valid && src_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_data", 32'(src_data), 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", 32'(src_data), 32'(e.d));
          chk("beat_flags", {28'd0, src_sop, src_eop, src_chan}, {28'd0, e.sop, e.eop, e.ch});
        end
      end
      prev_stall = src_valid && !src_ready;
      prev_data  = src_data;
      prev_flags = {src_sop, src_eop, src_chan};
    end
  end

  initial begin
    int cyc;
    int rd0, fd0, ur0, acc0;
    reset_n   = 1'b0;
    enable    = 1'b0;
    src_ready = 1'b1;
    refresh_fifo();
    tick(); tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Threshold + basic frame: 3 words stay idle, 4th starts, valid one cycle after decision
    enable = 1'b1;
    push_words(1, 3);
    for (int i = 0; i < 5; i++) tick();
    chk("below_threshold_valid", 32'(src_valid), 0);
    chk("below_threshold_rdreq_cnt", 32'(rd_cnt), 0);
    rd0 = rd_cnt; fd0 = fd_cnt;
    expect_frame(1, FL, 0);
    push_words(4, 1);
    tick();
    chk("decision_cycle_valid", 32'(src_valid), 0);
    push_words(5, 4);
    tick();
    chk("first_beat_valid", 32'(src_valid), 1);
    chk("first_beat_sop", 32'(src_sop), 1);
    run_until_done(0, 40, cyc);
    tick();
    chk("frame1_rdreq_cnt", 32'(rd_cnt - rd0), FL);
    chk("frame1_done_cnt", 32'(fd_cnt - fd0), 1);

    // enable=0 blocks a frame even with a full frame buffered; then backpressure
    enable = 1'b0;
    push_words(9, 8);
    for (int i = 0; i < 5; i++) tick();
    chk("enable_low_valid", 32'(src_valid), 0);
    chk("enable_low_state_usedw", 32'(fifo_usedw), 8);
    rd0 = rd_cnt;
    expect_frame(9, FL, 1);
    enable = 1'b1;
    run_until_done(1, 80, cyc);
    enable = 1'b0;
    tick();
    chk("frame2_rdreq_cnt", 32'(rd_cnt - rd0), FL);

    // Preloaded frame at full rate: enable to frame_done is 2 + FRAME_LEN cycles
    push_words(17, 8);
    expect_frame(17, FL, 2);
    tick();
    enable = 1'b1;
    run_until_done(0, 40, cyc);
    chk("frame3_cycle_count", 32'(cyc), FL + 2);
    tick();

    // Underrun: only 5 words for an 8-beat frame
    ur0 = ur_cnt;
`ifdef FRAME_ZERO_PAD_EN
    expect_frame(25, 5, 0);
    push_words(25, 5);
    run_until_done(0, 40, cyc);
    tick();
    chk("pad_underrun_cnt", 32'(ur_cnt - ur0), 3);
`else
    expect_frame(25, FL, 0);
    fd0 = fd_cnt;
    push_words(25, 5);
    for (int i = 0; i < 12; i++) tick();
    chk("stall_valid_low", 32'(src_valid), 0);
    chk("stall_underrun_pulse", 32'(underrun), 1);
    chk("stall_no_done", 32'(fd_cnt - fd0), 0);
    chk("stall_underrun_seen", 32'(ur_cnt - ur0 > 0), 1);
    push_words(30, 3);
    run_until_done(0, 40, cyc);
    tick();
`endif

    // Reset after the third accepted beat abandons the frame
    acc0 = acc_cnt;
    expect_frame(40, FL, 1);
    push_words(40, 8);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (acc_cnt - acc0 >= 3) break;
    end
    chk("midframe_three_beats", 32'(acc_cnt - acc0), 3);
    reset_n = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    exp_q.delete();
    mfifo.delete();
    refresh_fifo();
    tick();
    reset_n = 1'b1;
    tick();

    // Next frame after reset restarts at sop on channel 0
    expect_frame(50, FL, 0);
    push_words(50, 8);
    run_until_done(0, 40, cyc);
    tick(); tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_frame_feeder.md
# fft_frame_feeder

Parametrised successor to the FFT input-fill logic. Reads samples from a show-ahead FIFO and emits fixed-length Avalon-ST frames (valid/ready, sop/eop) to an FFT sink, with full backpressure support. Handles multiple round-robin channels, a programmable start threshold and mid-frame underrun handling. Sits between the input dual-clock FIFO (read side) and the forward FFT, all in the FFT clock domain.

## Interface
- DATA_W, 16, sample width
- FRAME_LEN, 4096, samples per frame (≥2)
- CNT_W, 13, width of FIFO fill count
- START_LVL, FRAME_LEN, FIFO fill level that starts a frame (1..FRAME_LEN)
- NUM_CH, 1, number of round-robin channels (≥1); CH_W = max(1, $clog2(NUM_CH))
- Clock and reset: single clock; reset is asynchronous, active-low.
- clk  in  1  FFT clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  allow new frames to start
- fifo_q  in  DATA_W  FIFO head word (show-ahead)
- fifo_empty  in  1  FIFO empty
- fifo_usedw  in  CNT_W  FIFO fill count
- fifo_rdreq  out  1  pop head word (combinational)
- src_data  out  DATA_W  sample to FFT sink_real
- src_valid  out  1  sample valid
- src_ready  in  1  FFT sink_ready
- src_sop  out  1  first sample of frame
- src_eop  out  1  last sample of frame
- src_chan  out  CH_W  channel of current frame
- frame_done  out  1  one-cycle pulse when the eop beat is accepted
- underrun  out  1  one-cycle pulse per beat in which FIFO was empty mid-frame

## Operation
- States: IDLE, STREAM.
- IDLE: enter STREAM when enable=1 and fifo_usedw ≥ START_LVL. enable is sampled only in IDLE; deasserting it mid-frame does not truncate the frame.
- STREAM: a one-entry output register holds {src_data, src_sop, src_eop}. The register may load when it is empty (src_valid=0) or is being consumed (src_valid & src_ready). A load occurs only while beats remain to be issued for the frame.
- Load with fifo_empty=0: fifo_rdreq=1 in the same cycle, src_data←fifo_q, src_valid←1.
- Load with fifo_empty=1 (underrun): underrun=1; behaviour per Configuration.
- idx counter (0..FRAME_LEN-1) counts loaded beats. src_sop=1 on idx 0, src_eop=1 on idx FRAME_LEN-1.
- After the last beat loads, no further rdreq is issued. When the eop beat is accepted: frame_done=1, src_valid←0 (unless a new frame beat loads, see Timing), and src_chan advances (wraps NUM_CH-1→0). The FSM returns to IDLE.
- src_data, sop, eop and chan hold stable while src_valid=1 and src_ready=0.
- fifo_rdreq is never asserted when fifo_empty=1, or in IDLE.

## Timing
- Reset values (async, immediate): state=IDLE, idx=0, src_valid=0, src_sop=0, src_eop=0, src_data=0, src_chan=0, frame_done=0, underrun=0; fifo_rdreq=0 while reset_n=0.
- Latency: src_valid rises one cycle after the IDLE→STREAM decision cycle (first load occurs in the first STREAM cycle).
- Throughput: with src_ready=1 and FIFO non-empty, one beat per cycle, so a frame takes FRAME_LEN consecutive cycles.
- Back-to-back frames: at least one IDLE cycle separates frames. frame_done to the next src_sop is ≥2 cycles.
- Reset mid-frame: the frame is abandoned; the next frame restarts at idx 0, chan 0 with sop.
- idx width = $clog2(FRAME_LEN); must not wrap inside a frame.

## Configuration
- FRAME_ZERO_PAD_EN defined: on underrun, load src_data=0, src_valid=1 and advance idx. The frame keeps a fixed cycle length under src_ready=1.
- FRAME_ZERO_PAD_EN undefined: on underrun, no load and src_valid stays 0. The frame stalls until the FIFO is non-empty. underrun pulses on every stalled load opportunity.

## Test plan
- Basic frame: FRAME_LEN=8, FIFO preloaded with 8 words 1..8, src_ready=1 -> 8 consecutive beats 1..8, sop on 1, eop on 8, frame_done once, 8 rdreq pulses.
- Backpressure: src_ready toggling 1,0,0,1 pattern -> no beat lost or duplicated, data/sop/eop stable while stalled, rdreq only on accepted-or-empty loads.
- Threshold: START_LVL=4, 3 words in FIFO -> stays IDLE. The 4th word arrives -> src_valid rises next cycle. enable=0 with 8 words -> no frame starts.
- Underrun: START_LVL=2, FRAME_LEN=8, only 5 words supplied. With FRAME_ZERO_PAD_EN: beats 1..5,0,0,0 and 3 underrun pulses. Without it: stall after 5 with src_valid=0 until more words are written.
- Channels: NUM_CH=3, 4 frames -> src_chan 0,1,2,0, constant within each frame.
- Reset mid-frame: reset_n low at beat 3 -> all outputs 0 immediately. After release, the next frame starts at sop with chan 0.
